// File: rtl/seq_alu_if.sv
//==============================================================================
// Module      : seq_alu_if
// Description : Request/response bundle for seq_alu. The master side issues
//               operations (in_valid/op/mext/a/b) and consumes results
//               (out_ready); the slave side is the ALU itself.
// Ports       : in_valid, in_ready, op[3:0], mext, a, b,
//               out_valid, out_ready, result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             mext;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, mext, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, mext, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
//==============================================================================
// Module      : seq_alu
// Description : Sequential integer ALU. Single-cycle logic/arithmetic group,
//               iterative shift-add multiplier and restoring divider (one bit
//               per clock), one operation in flight, valid/ready handshake on
//               both request and result sides.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - seq_alu_if.slave (request, operands, result)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    seq_alu_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [SHW-1:0]   c_last_iter = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_most_neg  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SHW-1:0]       r_cnt;
    logic [2:0]           r_op;       // group code of the iterative op
    logic                 r_neg;      // final result must be negated
    logic [WIDTH-1:0]     r_mcand;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_prod;     // {acc, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]     r_result;

    logic                 w_accept;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_alu;
    logic                 w_a_sgn;
    logic                 w_b_sgn;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_div_grp;
    logic                 w_div0;
    logic                 w_ovf;
    logic                 w_bypass;
    logic                 w_neg_in;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_mul_fix;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_div_val;
    logic [WIDTH-1:0]     w_div_fix;

    // in_ready is gated by rst_n so it reads 0 while reset is held
    assign bus.in_ready  = (r_state == S_IDLE) && rst_n;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign w_accept      = bus.in_valid && bus.in_ready;

    //--------------------------------------------------------------------------
    // Single-cycle group, evaluated on the request operands
    //--------------------------------------------------------------------------
    assign w_shamt = bus.b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.op)
            4'b0000: w_alu = bus.a + bus.b;
            4'b1000: w_alu = bus.a - bus.b;
            4'b0001: w_alu = bus.a << w_shamt;
            4'b0010: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b0011: w_alu = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'b0100: w_alu = bus.a ^ bus.b;
            4'b0101: w_alu = bus.a >> w_shamt;
            4'b1101: w_alu = $unsigned($signed(bus.a) >>> w_shamt);
            4'b0110: w_alu = bus.a | bus.b;
            4'b0111: w_alu = bus.a & bus.b;
            4'b1001: w_alu = bus.b;
            default: w_alu = '0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Multiply/divide setup: operand signs, magnitudes and special cases
    //--------------------------------------------------------------------------
    // a is signed for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM
    assign w_a_sgn = bus.a[WIDTH-1] &&
                     ((bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b010) ||
                      (bus.op[2:0] == 3'b100) || (bus.op[2:0] == 3'b110));
    assign w_b_sgn = bus.b[WIDTH-1] &&
                     ((bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b100) ||
                      (bus.op[2:0] == 3'b110));
    assign w_a_mag = w_a_sgn ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag = w_b_sgn ? (~bus.b + 1'b1) : bus.b;

    assign w_div_grp = bus.op[2];
    assign w_div0    = (bus.b == '0);
    // op[0]==0 within the divide group means a signed variant
    assign w_ovf     = !bus.op[0] && (bus.a == c_most_neg) && (&bus.b);
    assign w_bypass  = w_div_grp && (w_div0 || w_ovf);
    // remainder takes the dividend's sign; all other results take sign(a)^sign(b)
    assign w_neg_in  = (w_div_grp && bus.op[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);

    //--------------------------------------------------------------------------
    // Iteration datapath
    //--------------------------------------------------------------------------
    assign w_last = (r_cnt == c_last_iter);

    // shift-add: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole product right by one
    assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                        {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, r_prod[WIDTH-1:1]};
    assign w_mul_fix  = r_neg ? (~w_mul_next + 1'b1) : w_mul_next;

    // restoring division: shift next dividend bit into the remainder, trial
    // subtract, keep the difference only if it did not go negative
    assign w_shift    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_mcand};
    assign w_div_next = w_diff[WIDTH] ?
                        {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0} :
                        {w_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};
    assign w_div_val  = r_op[1] ? w_div_next[2*WIDTH-1:WIDTH] : w_div_next[WIDTH-1:0];
    assign w_div_fix  = r_neg ? (~w_div_val + 1'b1) : w_div_val;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!bus.mext || w_bypass) begin
                        w_state_nxt = S_DONE;
                    end else if (w_div_grp) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_MUL;
                    end
                end
            end
            S_MUL:   if (w_last) w_state_nxt = S_DONE;
            S_DIV:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op[2:0];
                        r_neg <= w_neg_in;
                        r_cnt <= '0;
                        if (!bus.mext) begin
                            r_result <= w_alu;
                        end else if (w_div_grp && w_div0) begin
                            r_result <= bus.op[1] ? bus.a : {WIDTH{1'b1}};
                        end else if (w_div_grp && w_ovf) begin
                            r_result <= bus.op[1] ? {WIDTH{1'b0}} : bus.a;
                        end else if (w_div_grp) begin
                            r_mcand <= w_b_mag;
                            r_prod  <= {{WIDTH{1'b0}}, w_a_mag};
                        end else begin
                            r_mcand <= w_a_mag;
                            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                        end
                    end
                end
                S_MUL: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        // sign fix-up folded into the final step
                        r_result <= (r_op == 3'b000) ? w_mul_fix[WIDTH-1:0]
                                                     : w_mul_fix[2*WIDTH-1:WIDTH];
                    end
                end
                S_DIV: begin
                    r_prod <= w_div_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_div_fix;
                    end
                end
                S_DONE: begin
                    // result reads 0 whenever no result is being offered
                    if (bus.out_ready) begin
                        r_result <= '0;
                    end
                end
                default: begin
                    r_result <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//==============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=32). Directed requests
//               with literal expectations plus a transaction-level reference
//               model compared against the outputs every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    //--------------------------------------------------------------------------
    // Reference arithmetic, written directly from the operation definitions
    //--------------------------------------------------------------------------
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic mx,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa;
        longint          sb;
        longint          ub;
        longint          p;
        longint unsigned pu;
        logic [W-1:0]    r;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        if (!mx) begin
            case (op)
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001: r = a << b[4:0];
                4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: r = (a < b) ? 32'd1 : 32'd0;
                4'b0100: r = a ^ b;
                4'b0101: r = a >> b[4:0];
                4'b1101: begin p = sa >>> b[4:0]; r = p[31:0]; end
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                4'b1001: r = b;
                default: r = '0;
            endcase
        end else begin
            case (op[2:0])
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: begin pu = longint'(a) * longint'(b); r = pu[63:32]; end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (ovf) r = a;
                    else begin p = sa / sb; r = p[31:0]; end
                end
                3'd5: r = (b == 0) ? '1 : a / b;
                3'd6: begin
                    if (b == 0) r = a;
                    else if (ovf) r = '0;
                    else begin p = sa % sb; r = p[31:0]; end
                end
                default: r = (b == 0) ? a : a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic mx,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        if (!mx) return 1;
        if (op[2] && (b == 0)) return 1;
        if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return W + 1;
    endfunction

    //--------------------------------------------------------------------------
    // Per-cycle compare against the transaction model
    //--------------------------------------------------------------------------
    logic         m_busy;
    logic         m_valid;
    int           m_lat;
    logic [W-1:0] m_exp;

    initial begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_lat   = 0;
        m_exp   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end
            chk("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            chk("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, (rst_n && !m_busy)});
            chk("cyc_result",    bus.result, m_valid ? m_exp : '0);
            // advance model to the state after the coming rising edge
            if (rst_n) begin
                if (m_valid) begin
                    if (bus.out_ready) begin
                        m_valid = 1'b0;
                        m_busy  = 1'b0;
                    end
                end else if (m_busy) begin
                    m_lat--;
                    if (m_lat == 0) m_valid = 1'b1;
                end else if (bus.in_valid) begin
                    m_busy = 1'b1;
                    m_exp  = ref_result(bus.op, bus.mext, bus.a, bus.b);
                    m_lat  = ref_latency(bus.op, bus.mext, bus.a, bus.b) - 1;
                    if (m_lat == 0) m_valid = 1'b1;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Directed stimulus
    //--------------------------------------------------------------------------
    // Issue one request (caller sits just after a rising edge, DUT idle),
    // scramble operands after accept, check literal result and latency,
    // optionally hold off the consumer for 'hold' cycles.
    task automatic run_op(input string nm, input logic [3:0] op, input logic mx,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat, input int hold);
        int n;
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.mext      = mx;
        bus.a         = a;
        bus.b         = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.op       = 4'($urandom);
        bus.mext     = 1'($urandom);
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        chk({nm, "_res"}, bus.result, exp);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                bus.in_valid = 1'b1;
                bus.op       = 4'b0000;
                bus.mext     = 1'b0;
                @(posedge clk); #1;
                chk({nm, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
                chk({nm, "_hold_res"},   bus.result, exp);
                chk({nm, "_hold_rdy"},   {31'd0, bus.in_ready}, 32'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({nm, "_idle_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.mext      = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_result",    bus.result, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // model pins
        chk("pin_mulh",  ref_result(4'b0001, 1'b1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("pin_div",   ref_result(4'b0100, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem",   ref_result(4'b0110, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_sra",   ref_result(4'b1101, 1'b0, 32'h8000_0000, 32'h24), 32'hF800_0000);

        // group 0
        run_op("add",   4'b0000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0);
        run_op("sra",   4'b1101, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1, 0);
        run_op("sub",   4'b1000, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
        run_op("sll",   4'b0001, 1'b0, 32'd1, 32'h3F, 32'h8000_0000, 1, 0);
        run_op("slt",   4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
        run_op("sltu",  4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        run_op("xor",   4'b0100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1, 0);
        run_op("srl",   4'b0101, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 1, 0);
        run_op("or",    4'b0110, 1'b0, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1, 0);
        run_op("and",   4'b0111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
        run_op("passb", 4'b1001, 1'b0, 32'h1111_1111, 32'hCAFE_BABE, 32'hCAFE_BABE, 1, 0);
        run_op("undef", 4'b1010, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 0);

        // multiply group
        run_op("mulh",   4'b0001, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("mul",    4'b0000, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, 0);
        run_op("mul_op3",4'b1000, 1'b1, 32'd6, 32'd7, 32'd42, 33, 0);
        run_op("mulhsu", 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhu",  4'b0011, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

        // divide group
        run_op("div",    4'b0100, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem",    4'b0110, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu",   4'b0101, 1'b1, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu",   4'b0111, 1'b1, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("divu0",  4'b0101, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  4'b0111, 1'b1, 32'd9, 32'd0, 32'd9, 1, 0);
        run_op("div_ov", 4'b0100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ov", 4'b0110, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // backpressure
        run_op("bp_xor", 4'b0100, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1, 5);
        run_op("bp_div", 4'b0100, 1'b1, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 33, 5);

        // reset in the middle of a DIVU
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'b0101;
        bus.mext      = 1'b1;
        bus.a         = 32'd1000;
        bus.b         = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstmid_result",    bus.result, 32'd0);
        chk("rstmid_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                chk("rstmid_stale", {31'd0, bus.out_valid}, 32'd0);
                break;
            end
        end
        run_op("add_after_rst", 4'b0000, 1'b0, 32'd2, 32'd3, 32'd5, 1, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  4  operation code, decoded when mext=0 (REQ-012).
REQ-008 mext  input  1  1 selects multiply/divide group; op[2:0] is the group code and op[3] is ignored.
REQ-009 a, b  input  WIDTH each  operands, signed or unsigned per op.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result; result  output  WIDTH  operation result.

Function
REQ-012 mext=0 codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1001 PASS-B; all other codes return 0.
REQ-013 Shifts use b[SHW-1:0] only; SLT/SLTU return 1 or 0 zero-extended; ADD/SUB wrap modulo 2^WIDTH.
REQ-014 mext=1 codes op[2:0]: 000 MUL (low half), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-016 Accept occurs on an edge where in_valid && in_ready; a, b, op and mext are registered at accept and later input changes have no effect.
REQ-017 Group-0 ops: IDLE->DONE; out_valid asserted on the first edge after accept (latency 1).
REQ-018 MUL group: iterative shift-add on operand magnitudes over 2·WIDTH-bit product, one bit per cycle, WIDTH cycles in MUL, then DONE (out_valid at accept+WIDTH+1); sign correction applied when entering DONE.
REQ-019 DIV group: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles in DIV, then DONE (latency WIDTH+1); quotient sign = sign(a) xor sign(b), remainder sign = sign(a).
REQ-020 Divide by zero: DIV/DIVU return all-ones, REM/REMU return a; bypasses DIV, latency 1.
REQ-021 Signed overflow (a = most negative, b = -1): DIV returns a, REM returns 0; bypasses DIV, latency 1.
REQ-022 DONE holds out_valid=1 and result stable until out_valid && out_ready, then goes to IDLE; the next request is accepted no earlier than the following edge.
REQ-023 out_valid=0 in all states except DONE; result is don't-care when out_valid=0 but is driven 0 outside DONE.
REQ-024 No pipelining: at most one operation in flight.

Reset
REQ-025 rst_n low forces state IDLE, out_valid=0, result=0, in_ready=1 (while low: in_ready=0), iteration counter 0, operand registers 0, immediately and without waiting for clk.
REQ-026 Reset asserted mid-MUL/DIV or in DONE discards the operation; no result is produced after release.
REQ-027 First accept possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-028 ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid one cycle later, result=0x80000000; SRA a=0x80000000 b=0x24 -> 0xF8000000.
REQ-029 MULH a=0x80000000 b=0x80000000 -> result=0x40000000 exactly 33 cycles after accept; MUL a=-3 b=7 -> 0xFFFFFFEB.
REQ-030 DIV a=-7 b=2 -> 0xFFFFFFFD; REM a=-7 b=2 -> 0xFFFFFFFF; DIVU a=7 b=0 -> 0xFFFFFFFF at latency 1; DIV a=0x80000000 b=-1 -> 0x80000000 at latency 1.
REQ-031 Backpressure: out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 rst_n pulsed low 10 cycles into a DIVU -> out_valid=0 and result=0 immediately; no stale result after release; next ADD 2+3 -> 5.
REQ-033 Operand change after accept during MULHU 0xFFFFFFFF×0xFFFFFFFF -> result still 0xFFFFFFFE.
